// File: rtl/lamp_sqrt_ctrl.sv
// rtl/lamp_sqrt_ctrl.sv - lamp float front/back-end controller for the sqrt/inv-sqrt iterative core
// Optional watchdog on the core handshake: define LAMP_SQRT_TIMEOUT_EN.
module lamp_sqrt_ctrl #(
  parameter int EXP_DW      = 8,
  parameter int FRAC_DW     = 7,
  parameter int BIAS        = 127,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid_i,
  output logic                      op_ready_o,
  input  logic [EXP_DW+FRAC_DW:0]   op_i,
  input  logic                      inv_i,
  output logic                      doSqrt_o,
  output logic                      special_case_o,
  output logic [FRAC_DW:0]          s_o,
  output logic                      is_exp_odd_o,
  output logic                      invSqrt_o,
  input  logic                      core_valid_i,
  input  logic [FRAC_DW:0]          core_res_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [EXP_DW+FRAC_DW:0]   res_o,
  output logic                      invalid_o,
  output logic                      divzero_o,
  output logic                      timeout_o
);

  localparam int FW = 1 + EXP_DW + FRAC_DW;
  localparam logic [FW-1:0]     QNAN    = {1'b0, {EXP_DW{1'b1}}, 1'b1, {(FRAC_DW-1){1'b0}}};
  localparam logic [FW-1:0]     POS_INF = {1'b0, {EXP_DW{1'b1}}, {FRAC_DW{1'b0}}};
  localparam logic [EXP_DW:0]   BIAS_W  = (EXP_DW+1)'(BIAS);
  localparam logic [EXP_DW-1:0] BIAS_E  = EXP_DW'(BIAS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t              state_q, state_d;
  logic                op_ready_q, op_ready_d;
  logic                do_sqrt_q, do_sqrt_d;
  logic                special_case_q, special_case_d;
  logic [FRAC_DW:0]    s_q, s_d;
  logic                odd_q, odd_d;
  logic                inv_q, inv_d;
  logic [EXP_DW-1:0]   k_q, k_d;
  logic                special_q, special_d;
  logic [FW-1:0]       spec_res_q, spec_res_d;
  logic                spec_invalid_q, spec_invalid_d;
  logic                spec_divzero_q, spec_divzero_d;
  logic                res_valid_q, res_valid_d;
  logic [FW-1:0]       res_q, res_d;
  logic                invalid_q, invalid_d;
  logic                divzero_q, divzero_d;
`ifdef LAMP_SQRT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
`endif

  logic                in_sign;
  logic [EXP_DW-1:0]   in_exp;
  logic [FRAC_DW-1:0]  in_frac;
  logic [EXP_DW:0]     e_in;
  logic                cls_special, cls_invalid, cls_divzero;
  logic [FW-1:0]       cls_res;

  assign in_sign = op_i[FW-1];
  assign in_exp  = op_i[FW-2:FRAC_DW];
  assign in_frac = op_i[FRAC_DW-1:0];
  // e fits in EXP_DW+1 bits; bit 0 is the parity and the rest is e>>>1.
  assign e_in    = {1'b0, in_exp} - BIAS_W;

  always_comb begin
    cls_special = 1'b1;
    cls_invalid = 1'b0;
    cls_divzero = 1'b0;
    cls_res     = '0;
    if (in_exp == '1 && in_frac != '0) begin
      cls_res = QNAN;
    end else if (in_exp == '0) begin
      // Denormals are flushed, so they share the signed-zero handling.
      if (inv_i) begin
        cls_res     = {in_sign, {EXP_DW{1'b1}}, {FRAC_DW{1'b0}}};
        cls_divzero = 1'b1;
      end else begin
        cls_res = {in_sign, {(FW-1){1'b0}}};
      end
    end else if (in_sign) begin
      cls_res     = QNAN;
      cls_invalid = 1'b1;
    end else if (in_exp == '1) begin
      cls_res = inv_i ? '0 : POS_INF;
    end else begin
      cls_special = 1'b0;
    end
  end

  logic [EXP_DW-1:0]  exp_unb;
  logic [EXP_DW-1:0]  adj;
  logic [FRAC_DW-1:0] norm_frac;
  logic [EXP_DW-1:0]  res_exp;
  logic [FW-1:0]      norm_res;

  always_comb begin
    exp_unb = inv_q ? (EXP_DW'(0) - k_q) : k_q;
    if (core_res_i[FRAC_DW]) begin
      adj       = EXP_DW'(0);
      norm_frac = core_res_i[FRAC_DW-1:0];
    end else if (core_res_i[FRAC_DW-1]) begin
      adj       = EXP_DW'(1);
      norm_frac = {core_res_i[FRAC_DW-2:0], 1'b0};
    end else begin
      adj       = EXP_DW'(2);
      norm_frac = {core_res_i[FRAC_DW-3:0], 2'b00};
    end
    res_exp  = exp_unb - adj + BIAS_E;
    norm_res = {1'b0, res_exp, norm_frac};
  end

  always_comb begin
    state_d        = state_q;
    op_ready_d     = op_ready_q;
    do_sqrt_d      = 1'b0;
    special_case_d = 1'b0;
    s_d            = s_q;
    odd_d          = odd_q;
    inv_d          = inv_q;
    k_d            = k_q;
    special_d      = special_q;
    spec_res_d     = spec_res_q;
    spec_invalid_d = spec_invalid_q;
    spec_divzero_d = spec_divzero_q;
    res_valid_d    = res_valid_q;
    res_d          = res_q;
    invalid_d      = invalid_q;
    divzero_d      = divzero_q;
`ifdef LAMP_SQRT_TIMEOUT_EN
    cnt_d          = cnt_q;
    timeout_d      = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (op_valid_i) begin
          state_d        = ISSUE;
          op_ready_d     = 1'b0;
          do_sqrt_d      = ~cls_special;
          special_case_d = cls_special;
          s_d            = {1'b1, in_frac};
          odd_d          = e_in[0];
          k_d            = e_in[EXP_DW:1];
          inv_d          = inv_i;
          special_d      = cls_special;
          spec_res_d     = cls_res;
          spec_invalid_d = cls_invalid;
          spec_divzero_d = cls_divzero;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef LAMP_SQRT_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (special_q) begin
          state_d     = OUT;
          res_valid_d = 1'b1;
          res_d       = spec_res_q;
          invalid_d   = spec_invalid_q;
          divzero_d   = spec_divzero_q;
`ifdef LAMP_SQRT_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end else if (core_valid_i) begin
          state_d     = OUT;
          res_valid_d = 1'b1;
          res_d       = norm_res;
          invalid_d   = 1'b0;
          divzero_d   = 1'b0;
`ifdef LAMP_SQRT_TIMEOUT_EN
          timeout_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d     = OUT;
          res_valid_d = 1'b1;
          res_d       = QNAN;
          invalid_d   = 1'b1;
          divzero_d   = 1'b0;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      OUT: begin
        if (res_ready_i) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          op_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      op_ready_q     <= 1'b1;
      do_sqrt_q      <= 1'b0;
      special_case_q <= 1'b0;
      s_q            <= '0;
      odd_q          <= 1'b0;
      inv_q          <= 1'b0;
      k_q            <= '0;
      special_q      <= 1'b0;
      spec_res_q     <= '0;
      spec_invalid_q <= 1'b0;
      spec_divzero_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_q          <= '0;
      invalid_q      <= 1'b0;
      divzero_q      <= 1'b0;
`ifdef LAMP_SQRT_TIMEOUT_EN
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      op_ready_q     <= op_ready_d;
      do_sqrt_q      <= do_sqrt_d;
      special_case_q <= special_case_d;
      s_q            <= s_d;
      odd_q          <= odd_d;
      inv_q          <= inv_d;
      k_q            <= k_d;
      special_q      <= special_d;
      spec_res_q     <= spec_res_d;
      spec_invalid_q <= spec_invalid_d;
      spec_divzero_q <= spec_divzero_d;
      res_valid_q    <= res_valid_d;
      res_q          <= res_d;
      invalid_q      <= invalid_d;
      divzero_q      <= divzero_d;
`ifdef LAMP_SQRT_TIMEOUT_EN
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign op_ready_o     = op_ready_q;
  assign doSqrt_o       = do_sqrt_q;
  assign special_case_o = special_case_q;
  assign s_o            = s_q;
  assign is_exp_odd_o   = odd_q;
  assign invSqrt_o      = inv_q;
  assign res_valid_o    = res_valid_q;
  assign res_o          = res_q;
  assign invalid_o      = invalid_q;
  assign divzero_o      = divzero_q;
`ifdef LAMP_SQRT_TIMEOUT_EN
  assign timeout_o      = timeout_q;
`else
  assign timeout_o      = 1'b0;
`endif

endmodule
